// File: rtl/alu_br_resolve.sv
// Keeps the oldest ALU mispredict report (relative to commit_head) and offers it as a fetch redirect.
// Drives commit_kill for entries younger than the held branch until the post-handshake shadow expires.
module alu_br_resolve #(
  parameter int NALU     = 2,
  parameter int RV       = 64,
  parameter int NCOMMIT  = 32,
  parameter int LNCOMMIT = 5,
  parameter int BDEC     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [LNCOMMIT-1:0]        commit_head,
  input  logic [NALU-1:0]            br_enable,
  input  logic [NALU*LNCOMMIT-1:0]   br_addr,
  input  logic [NALU*(RV-1)-1:0]     br_dest,
  input  logic [NALU-1:0]            br_short,
  input  logic [NALU*(BDEC-1)-1:0]   br_dec,
  output logic                       redirect_valid,
  input  logic                       redirect_ready,
  output logic [RV-2:0]              redirect_pc,
  output logic [LNCOMMIT-1:0]        redirect_addr,
  output logic                       redirect_short,
  output logic [BDEC-2:0]            redirect_dec,
  output logic [NCOMMIT-1:0]         commit_kill,
  output logic                       busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, SHADOW = 2'd2} state_t;

  state_t               state, state_nxt;
  logic [1:0]           scnt, scnt_nxt;
  logic                 take;
  logic                 older;
  logic                 cand_v;
  logic [LNCOMMIT-1:0]  cand_addr, cand_age, nxt_addr;
  logic [RV-2:0]        cand_dest;
  logic                 cand_short;
  logic [BDEC-2:0]      cand_dec;
  logic [NCOMMIT-1:0]   kill_nxt;

  function automatic logic [LNCOMMIT-1:0] age(input logic [LNCOMMIT-1:0] x,
                                              input logic [LNCOMMIT-1:0] h);
    return x - h;
  endfunction

  // Strict less-than keeps the lowest ALU index on an age tie.
  always_comb begin
    cand_v     = 1'b0;
    cand_addr  = '0;
    cand_age   = '1;
    cand_dest  = '0;
    cand_short = 1'b0;
    cand_dec   = '0;
    for (int k = 0; k < NALU; k++) begin
      if (br_enable[k] &&
          (!cand_v || age(br_addr[k*LNCOMMIT +: LNCOMMIT], commit_head) < cand_age)) begin
        cand_v     = 1'b1;
        cand_addr  = br_addr[k*LNCOMMIT +: LNCOMMIT];
        cand_age   = age(br_addr[k*LNCOMMIT +: LNCOMMIT], commit_head);
        cand_dest  = br_dest[k*(RV-1) +: (RV-1)];
        cand_short = br_short[k];
        cand_dec   = br_dec[k*(BDEC-1) +: (BDEC-1)];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    scnt_nxt  = scnt;
    take      = 1'b0;
    older     = cand_v && (cand_age < age(redirect_addr, commit_head));
    case (state)
      IDLE: begin
        if (cand_v) begin
          take      = 1'b1;
          state_nxt = PEND;
        end
      end
      PEND: begin
        // An older report wins over a same-cycle handshake; fetch must take it too.
        if (older) begin
          take = 1'b1;
        end else if (redirect_ready) begin
          state_nxt = SHADOW;
          scnt_nxt  = 2'd2;
        end
      end
      SHADOW: begin
        if (older) begin
          take      = 1'b1;
          state_nxt = PEND;
        end else begin
          scnt_nxt = scnt - 2'd1;
          if (scnt == 2'd1) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
      scnt_nxt  = 2'd0;
      take      = 1'b0;
    end
  end

  always_comb begin
    kill_nxt = '0;
    nxt_addr = take ? cand_addr : redirect_addr;
    for (int i = 0; i < NCOMMIT; i++) begin
      kill_nxt[i] = (state_nxt != IDLE) &&
                    (age(LNCOMMIT'(i), commit_head) > age(nxt_addr, commit_head));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      scnt           <= 2'd0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      redirect_addr  <= '0;
      redirect_short <= 1'b0;
      redirect_dec   <= '0;
      commit_kill    <= '0;
      busy           <= 1'b0;
    end else begin
      state          <= state_nxt;
      scnt           <= scnt_nxt;
      redirect_valid <= (state_nxt == PEND);
      busy           <= (state_nxt != IDLE);
      commit_kill    <= kill_nxt;
      if (flush) begin
        redirect_pc    <= '0;
        redirect_addr  <= '0;
        redirect_short <= 1'b0;
        redirect_dec   <= '0;
      end else if (take) begin
        redirect_pc    <= cand_dest;
        redirect_addr  <= cand_addr;
        redirect_short <= cand_short;
        redirect_dec   <= cand_dec;
      end
    end
  end

endmodule

// File: tb/tb_alu_br_resolve.sv
// Directed bench for alu_br_resolve: hand-computed redirect payloads and kill masks.
module tb_alu_br_resolve;
  localparam int NALU = 2, RV = 64, NCOMMIT = 32, LNCOMMIT = 5, BDEC = 4;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     flush;
  logic [LNCOMMIT-1:0]      commit_head;
  logic [NALU-1:0]          br_enable;
  logic [NALU*LNCOMMIT-1:0] br_addr;
  logic [NALU*(RV-1)-1:0]   br_dest;
  logic [NALU-1:0]          br_short;
  logic [NALU*(BDEC-1)-1:0] br_dec;
  logic                     redirect_valid;
  logic                     redirect_ready;
  logic [RV-2:0]            redirect_pc;
  logic [LNCOMMIT-1:0]      redirect_addr;
  logic                     redirect_short;
  logic [BDEC-2:0]          redirect_dec;
  logic [NCOMMIT-1:0]       commit_kill;
  logic                     busy;

  int total = 0;
  int bad   = 0;

  alu_br_resolve #(.NALU(NALU), .RV(RV), .NCOMMIT(NCOMMIT), .LNCOMMIT(LNCOMMIT), .BDEC(BDEC)) dut (
    .clk(clk), .reset(reset), .flush(flush), .commit_head(commit_head),
    .br_enable(br_enable), .br_addr(br_addr), .br_dest(br_dest), .br_short(br_short),
    .br_dec(br_dec), .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .redirect_addr(redirect_addr), .redirect_short(redirect_short),
    .redirect_dec(redirect_dec), .commit_kill(commit_kill), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    br_enable      = '0;
    redirect_ready = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic report(input int k, input int addr, input logic [RV-2:0] dest,
                        input logic sh, input int dec);
    br_enable[k]                      = 1'b1;
    br_addr[k*LNCOMMIT +: LNCOMMIT]   = LNCOMMIT'(addr);
    br_dest[k*(RV-1) +: (RV-1)]       = dest;
    br_short[k]                       = sh;
    br_dec[k*(BDEC-1) +: (BDEC-1)]    = (BDEC-1)'(dec);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    total++;
    if ({redirect_valid, busy, commit_kill, redirect_addr, redirect_pc} !== '0) begin
      bad++;
      $display("FAIL reset_state: valid=%0b busy=%0b kill=%h addr=%0d pc=%h expected all zero",
               redirect_valid, busy, commit_kill, redirect_addr, redirect_pc);
    end
  endtask

  task automatic test_single();
    commit_head = 5'd0;
    report(0, 5, 63'h800, 1'b1, 3);
    tick();
    total++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 63'h800 || redirect_addr !== 5'd5 ||
        redirect_short !== 1'b1 || redirect_dec !== 3'd3 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_payload: valid=%0b pc=%h addr=%0d short=%0b dec=%0d busy=%0b expected 1 800 5 1 3 1",
               redirect_valid, redirect_pc, redirect_addr, redirect_short, redirect_dec, busy);
    end
    total++;
    if (commit_kill !== 32'hFFFFFFC0) begin
      bad++;
      $display("FAIL single_kill: got %h expected ffffffc0", commit_kill);
    end
    redirect_ready = 1'b1;
    tick();
    total++;
    if (redirect_valid !== 1'b0 || busy !== 1'b1 || commit_kill !== 32'hFFFFFFC0) begin
      bad++;
      $display("FAIL shadow1: valid=%0b busy=%0b kill=%h expected 0 1 ffffffc0",
               redirect_valid, busy, commit_kill);
    end
    tick();
    total++;
    if (redirect_valid !== 1'b0 || busy !== 1'b1 || commit_kill !== 32'hFFFFFFC0) begin
      bad++;
      $display("FAIL shadow2: valid=%0b busy=%0b kill=%h expected 0 1 ffffffc0",
               redirect_valid, busy, commit_kill);
    end
    tick();
    total++;
    if (busy !== 1'b0 || commit_kill !== '0 || redirect_valid !== 1'b0) begin
      bad++;
      $display("FAIL shadow_exit: valid=%0b busy=%0b kill=%h expected 0 0 0",
               redirect_valid, busy, commit_kill);
    end
  endtask

  task automatic test_select();
    commit_head = 5'd0;
    report(0, 9, 63'h900, 1'b0, 1);
    report(1, 3, 63'h300, 1'b1, 6);
    tick();
    total++;
    if (redirect_addr !== 5'd3 || redirect_pc !== 63'h300 || redirect_dec !== 3'd6 ||
        commit_kill !== 32'hFFFFFFF0) begin
      bad++;
      $display("FAIL select_oldest: addr=%0d pc=%h dec=%0d kill=%h expected 3 300 6 fffffff0",
               redirect_addr, redirect_pc, redirect_dec, commit_kill);
    end
    do_flush();
    report(0, 4, 63'h111, 1'b0, 2);
    report(1, 4, 63'h222, 1'b1, 5);
    tick();
    total++;
    if (redirect_addr !== 5'd4 || redirect_pc !== 63'h111 || redirect_short !== 1'b0 ||
        redirect_dec !== 3'd2) begin
      bad++;
      $display("FAIL select_tie: addr=%0d pc=%h short=%0b dec=%0d expected 4 111 0 2",
               redirect_addr, redirect_pc, redirect_short, redirect_dec);
    end
    do_flush();
  endtask

  task automatic test_wrap();
    commit_head = 5'd30;
    report(0, 1, 63'hA1, 1'b0, 0);
    report(1, 31, 63'hB1, 1'b0, 0);
    tick();
    total++;
    if (redirect_addr !== 5'd31 || redirect_pc !== 63'hB1 || commit_kill !== 32'h3FFFFFFF) begin
      bad++;
      $display("FAIL wrap: addr=%0d pc=%h kill=%h expected 31 b1 3fffffff",
               redirect_addr, redirect_pc, commit_kill);
    end
    do_flush();
    commit_head = 5'd0;
  endtask

  task automatic test_replace();
    commit_head = 5'd0;
    report(0, 10, 63'hA0, 1'b0, 0);
    tick();
    report(1, 7, 63'h70, 1'b0, 0);
    tick();
    total++;
    if (redirect_valid !== 1'b1 || redirect_addr !== 5'd7 || redirect_pc !== 63'h70 ||
        commit_kill !== 32'hFFFFFF00) begin
      bad++;
      $display("FAIL replace_older: valid=%0b addr=%0d pc=%h kill=%h expected 1 7 70 ffffff00",
               redirect_valid, redirect_addr, redirect_pc, commit_kill);
    end
    report(0, 12, 63'hC0, 1'b0, 0);
    tick();
    total++;
    if (redirect_addr !== 5'd7 || redirect_pc !== 63'h70 || commit_kill !== 32'hFFFFFF00) begin
      bad++;
      $display("FAIL drop_younger: addr=%0d pc=%h kill=%h expected 7 70 ffffff00",
               redirect_addr, redirect_pc, commit_kill);
    end
    redirect_ready = 1'b1;
    report(0, 2, 63'h20, 1'b0, 0);
    tick();
    total++;
    if (redirect_valid !== 1'b1 || redirect_addr !== 5'd2 || commit_kill !== 32'hFFFFFFF8) begin
      bad++;
      $display("FAIL handshake_vs_older: valid=%0b addr=%0d kill=%h expected 1 2 fffffff8",
               redirect_valid, redirect_addr, commit_kill);
    end
    redirect_ready = 1'b1;
    tick();
    tick();
    tick();
    total++;
    if (busy !== 1'b0 || redirect_valid !== 1'b0) begin
      bad++;
      $display("FAIL replace_drain: busy=%0b valid=%0b expected 0 0", busy, redirect_valid);
    end
  endtask

  task automatic test_shadow();
    commit_head = 5'd0;
    report(0, 5, 63'h50, 1'b0, 0);
    tick();
    redirect_ready = 1'b1;
    tick();
    report(1, 8, 63'h80, 1'b0, 0);
    tick();
    total++;
    if (redirect_valid !== 1'b0 || busy !== 1'b1 || redirect_addr !== 5'd5) begin
      bad++;
      $display("FAIL shadow_drop: valid=%0b busy=%0b addr=%0d expected 0 1 5",
               redirect_valid, busy, redirect_addr);
    end
    tick();
    total++;
    if (busy !== 1'b0 || commit_kill !== '0) begin
      bad++;
      $display("FAIL shadow_idle: busy=%0b kill=%h expected 0 0", busy, commit_kill);
    end
    report(0, 5, 63'h50, 1'b0, 0);
    tick();
    redirect_ready = 1'b1;
    tick();
    report(1, 2, 63'h2A, 1'b1, 4);
    tick();
    total++;
    if (redirect_valid !== 1'b1 || redirect_addr !== 5'd2 || redirect_pc !== 63'h2A ||
        commit_kill !== 32'hFFFFFFF8) begin
      bad++;
      $display("FAIL shadow_older: valid=%0b addr=%0d pc=%h kill=%h expected 1 2 2a fffffff8",
               redirect_valid, redirect_addr, redirect_pc, commit_kill);
    end
    do_flush();
  endtask

  task automatic test_flush();
    commit_head = 5'd0;
    flush = 1'b1;
    report(0, 6, 63'h60, 1'b1, 7);
    tick();
    total++;
    if ({redirect_valid, busy, commit_kill, redirect_addr, redirect_pc} !== '0) begin
      bad++;
      $display("FAIL flush_ignores: valid=%0b busy=%0b kill=%h addr=%0d pc=%h expected all zero",
               redirect_valid, busy, commit_kill, redirect_addr, redirect_pc);
    end
  endtask

  task automatic test_reset_mid();
    report(0, 5, 63'h55, 1'b0, 0);
    tick();
    total++;
    if (redirect_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_pre: valid=%0b expected 1", redirect_valid);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (redirect_valid !== 1'b0 || commit_kill !== '0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: valid=%0b kill=%h busy=%0b expected 0 0 0",
               redirect_valid, commit_kill, busy);
    end
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    commit_head = '0;
    br_enable = '0;
    br_addr = '0;
    br_dest = '0;
    br_short = '0;
    br_dec = '0;
    redirect_ready = 1'b0;
    tick();
    tick();
    test_reset();
    reset = 1'b0;
    tick();
    test_single();
    test_select();
    test_wrap();
    test_replace();
    test_shadow();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
